// File: rtl/reg_port_sequencer.sv
// reg_port_sequencer
// Initiator-side controller for a 4 x 8-bit single-port register bank.
// It accepts one request at a time, reads source registers A and B over the
// shared bank port in consecutive cycles, and offers the operand pair to the
// ALU with a valid/ready handshake. It then waits for the ALU result and
// optionally writes that result back to a destination register.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   reqValid/reqReady     upstream request handshake
//   reqRa/reqRb/reqRd     source A, source B and destination register indices
//   reqWb                 1 = write the result back to reqRd
//   bankWR/bankRs/bankData  register bank strobe, index and write data
//   bankVal               register bank read value (combinational from bankRs)
//   opValid/opReady/opA/opB  operand handshake toward the ALU
//   resValid/resData      ALU result
//   done                  one-cycle pulse per completed request
//   opsDone               completed-request count, wraps at 256
//
// All outputs are registers. Each one is loaded from the value that its
// next state calls for, so each output is valid for the whole cycle of the
// state that owns it.
module reg_port_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       reqValid,
    output logic       reqReady,
    input  logic [1:0] reqRa,
    input  logic [1:0] reqRb,
    input  logic [1:0] reqRd,
    input  logic       reqWb,
    output logic       bankWR,
    output logic [1:0] bankRs,
    output logic [7:0] bankData,
    input  logic [7:0] bankVal,
    output logic       opValid,
    input  logic       opReady,
    output logic [7:0] opA,
    output logic [7:0] opB,
    input  logic       resValid,
    input  logic [7:0] resData,
    output logic       done,
    output logic [7:0] opsDone
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ_A   = 3'd1,
        S_READ_B   = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_RES = 3'd4,
        S_WRITE    = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_complete;
    logic [1:0] w_nx_bank_rs;
    logic [7:0] w_nx_bank_data;

    logic [1:0] r_ra;
    logic [1:0] r_rb;
    logic [1:0] r_rd;
    logic       r_wb;

    logic       r_req_ready;
    logic       r_bank_wr;
    logic [1:0] r_bank_rs;
    logic [7:0] r_bank_data;
    logic       r_op_valid;
    logic [7:0] r_op_a;
    logic [7:0] r_op_b;
    logic       r_done;
    logic [7:0] r_ops_done;

    // Next-state decode and the completion condition.
    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reqValid) begin
                    w_next = S_READ_A;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_READ_A: w_next = S_READ_B;
            S_READ_B: w_next = S_ISSUE;
            S_ISSUE: begin
                if (opReady) begin
                    w_next = S_WAIT_RES;
                end else begin
                    w_next = S_ISSUE;
                end
            end
            S_WAIT_RES: begin
                if (resValid && r_wb) begin
                    w_next = S_WRITE;
                end else if (resValid) begin
                    w_next     = S_IDLE;
                    w_complete = 1'b1;
                end else begin
                    w_next = S_WAIT_RES;
                end
            end
            S_WRITE: begin
                w_next     = S_IDLE;
                w_complete = 1'b1;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Bank port values for the cycle after this edge, selected by next state.
    // READ_A can only be entered from IDLE, so it takes reqRa directly.
    // The latched copy of Ra is not loaded until that same edge.
    always_comb begin
        w_nx_bank_rs   = 2'd0;
        w_nx_bank_data = 8'd0;
        case (w_next)
            S_READ_A: w_nx_bank_rs = reqRa;
            S_READ_B: w_nx_bank_rs = r_rb;
            S_WRITE: begin
                w_nx_bank_rs   = r_rd;
                w_nx_bank_data = resData;
            end
            default: begin
                w_nx_bank_rs   = 2'd0;
                w_nx_bank_data = 8'd0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Latch the request fields when the request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ra <= 2'd0;
            r_rb <= 2'd0;
            r_rd <= 2'd0;
            r_wb <= 1'b0;
        end else if ((r_state == S_IDLE) && reqValid) begin
            r_ra <= reqRa;
            r_rb <= reqRb;
            r_rd <= reqRd;
            r_wb <= reqWb;
        end
    end

    // Handshake and bank port output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_ready <= 1'b1;
            r_bank_wr   <= 1'b0;
            r_bank_rs   <= 2'd0;
            r_bank_data <= 8'd0;
            r_op_valid  <= 1'b0;
        end else begin
            r_req_ready <= (w_next == S_IDLE);
            r_bank_wr   <= (w_next == S_WRITE);
            r_bank_rs   <= w_nx_bank_rs;
            r_bank_data <= w_nx_bank_data;
            r_op_valid  <= (w_next == S_ISSUE);
        end
    end

    // Operand capture. Each operand holds its value until its read cycle
    // comes round again, so it stays stable throughout ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_a <= 8'd0;
            r_op_b <= 8'd0;
        end else begin
            if (r_state == S_READ_A) begin
                r_op_a <= bankVal;
            end
            if (r_state == S_READ_B) begin
                r_op_b <= bankVal;
            end
        end
    end

    // Completion pulse and the wrapping completion counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done     <= 1'b0;
            r_ops_done <= 8'd0;
        end else begin
            r_done <= w_complete;
            if (w_complete) begin
                r_ops_done <= r_ops_done + 8'd1;
            end
        end
    end

    assign reqReady = r_req_ready;
    assign bankWR   = r_bank_wr;
    assign bankRs   = r_bank_rs;
    assign bankData = r_bank_data;
    assign opValid  = r_op_valid;
    assign opA      = r_op_a;
    assign opB      = r_op_b;
    assign done     = r_done;
    assign opsDone  = r_ops_done;

endmodule

// File: tb/tb_reg_port_sequencer.sv
// Directed testbench for reg_port_sequencer. It contains a behavioural model
// of the register bank. The ALU side is driven directly by the stimulus.
module tb_reg_port_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       reqValid;
    logic       reqReady;
    logic [1:0] reqRa;
    logic [1:0] reqRb;
    logic [1:0] reqRd;
    logic       reqWb;
    logic       bankWR;
    logic [1:0] bankRs;
    logic [7:0] bankData;
    logic [7:0] bankVal;
    logic       opValid;
    logic       opReady;
    logic [7:0] opA;
    logic [7:0] opB;
    logic       resValid;
    logic [7:0] resData;
    logic       done;
    logic [7:0] opsDone;

    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int done_count = 0;

    // Bank contents: s0, s1, t0, t1.
    logic [7:0] bank_m [4] = '{8'h12, 8'h00, 8'h56, 8'h34};

    always #5 clk = ~clk;

    assign bankVal = bank_m[bankRs];

    // Register bank write port, plus counters of write strobes and done pulses.
    always @(posedge clk) begin
        if (bankWR) begin
            bank_m[bankRs] <= bankData;
            wr_count       <= wr_count + 1;
        end
        if (done) begin
            done_count <= done_count + 1;
        end
    end

    reg_port_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .reqValid (reqValid),
        .reqReady (reqReady),
        .reqRa    (reqRa),
        .reqRb    (reqRb),
        .reqRd    (reqRd),
        .reqWb    (reqWb),
        .bankWR   (bankWR),
        .bankRs   (bankRs),
        .bankData (bankData),
        .bankVal  (bankVal),
        .opValid  (opValid),
        .opReady  (opReady),
        .opA      (opA),
        .opB      (opB),
        .resValid (resValid),
        .resData  (resData),
        .done     (done),
        .opsDone  (opsDone)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request with an ALU that is always ready and has its result
    // waiting. The task is entered and left at a falling edge. It returns the
    // number of cycles from the accept edge to done high.
    task automatic do_req(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rd,
                          input logic wb, input logic [7:0] res, output int lat);
        reqValid = 1'b1;
        reqRa    = ra;
        reqRb    = rb;
        reqRd    = rd;
        reqWb    = wb;
        opReady  = 1'b1;
        resValid = 1'b1;
        resData  = res;
        @(negedge clk);
        reqValid = 1'b0;
        lat = 0;
        while ((done !== 1'b1) && (lat < 20)) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat;
        int wr_snap;
        int done_snap;

        rst      = 1'b1;
        reqValid = 1'b0;
        reqRa    = 2'd0;
        reqRb    = 2'd0;
        reqRd    = 2'd0;
        reqWb    = 1'b0;
        opReady  = 1'b0;
        resValid = 1'b0;
        resData  = 8'd0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst_reqReady", 32'(reqReady), 32'd1);
        chk("rst_opValid", 32'(opValid), 32'd0);
        chk("rst_bankWR", 32'(bankWR), 32'd0);
        chk("rst_opsDone", 32'(opsDone), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic writeback: s0(0x12) op t1(0x34) -> s1 = 0x46.
        reqValid = 1'b1; reqRa = 2'd0; reqRb = 2'd3; reqRd = 2'd1; reqWb = 1'b1;
        opReady = 1'b1; resValid = 1'b1; resData = 8'h46;
        @(negedge clk);
        chk("wb_readA_reqReady", 32'(reqReady), 32'd0);
        chk("wb_readA_bankRs", 32'(bankRs), 32'd0);
        reqValid = 1'b0;
        @(negedge clk);
        chk("wb_readB_bankRs", 32'(bankRs), 32'd3);
        chk("wb_opA", 32'(opA), 32'h12);
        @(negedge clk);
        chk("wb_issue_opValid", 32'(opValid), 32'd1);
        chk("wb_opB", 32'(opB), 32'h34);
        @(negedge clk);
        chk("wb_wait_opValid", 32'(opValid), 32'd0);
        @(negedge clk);
        chk("wb_write_bankWR", 32'(bankWR), 32'd1);
        chk("wb_write_bankRs", 32'(bankRs), 32'd1);
        chk("wb_write_bankData", 32'(bankData), 32'h46);
        chk("wb_write_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("wb_done", 32'(done), 32'd1);
        chk("wb_opsDone", 32'(opsDone), 32'd1);
        chk("wb_bankWR_low", 32'(bankWR), 32'd0);
        chk("wb_bank_s1", 32'(bank_m[1]), 32'h46);
        chk("wb_wr_count", 32'(wr_count), 32'd1);

        // No writeback: done four cycles after the accept edge, no write strobe.
        do_req(2'd0, 2'd3, 2'd2, 1'b0, 8'h99, lat);
        chk("nowb_latency", 32'(lat), 32'd4);
        chk("nowb_wr_count", 32'(wr_count), 32'd1);
        chk("nowb_opsDone", 32'(opsDone), 32'd2);
        chk("nowb_bank_t0", 32'(bank_m[2]), 32'h56);

        // Ra = Rb = Rd = t0 with writeback: equal operands, five-cycle latency.
        do_req(2'd2, 2'd2, 2'd2, 1'b1, 8'h77, lat);
        chk("same_latency", 32'(lat), 32'd5);
        chk("same_opA", 32'(opA), 32'h56);
        chk("same_opB", 32'(opB), 32'h56);
        chk("same_bank_t0", 32'(bank_m[2]), 32'h77);
        chk("same_opsDone", 32'(opsDone), 32'd3);

        // Backpressure: the ALU holds off for 7 cycles while upstream keeps
        // reqValid asserted.
        opReady = 1'b0; resValid = 1'b0;
        reqValid = 1'b1; reqRa = 2'd3; reqRb = 2'd0; reqRd = 2'd0; reqWb = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            chk("bp_opValid", 32'(opValid), 32'd1);
            chk("bp_opA", 32'(opA), 32'h34);
            chk("bp_opB", 32'(opB), 32'h12);
            chk("bp_reqReady", 32'(reqReady), 32'd0);
            @(negedge clk);
        end
        opReady = 1'b1;
        @(negedge clk);
        chk("bp_wait_opValid", 32'(opValid), 32'd0);
        chk("bp_wait_reqReady", 32'(reqReady), 32'd0);
        opReady = 1'b0; resValid = 1'b1; resData = 8'h21;
        @(negedge clk);
        chk("bp_done", 32'(done), 32'd1);
        chk("bp_idle_reqReady", 32'(reqReady), 32'd1);
        chk("bp_opsDone", 32'(opsDone), 32'd4);
        @(negedge clk);
        chk("bp_held_accept", 32'(reqReady), 32'd0);
        chk("bp_held_bankRs", 32'(bankRs), 32'd3);
        reqValid = 1'b0; opReady = 1'b1;
        lat = 0;
        while ((done !== 1'b1) && (lat < 20)) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_second_done", 32'(done), 32'd1);
        chk("bp_second_opsDone", 32'(opsDone), 32'd5);
        chk("bp_wr_count", 32'(wr_count), 32'd2);

        // Spurious inputs: opReady in IDLE, resValid during READ_A.
        opReady = 1'b1; resValid = 1'b0;
        repeat (2) @(negedge clk);
        chk("sp_idle_reqReady", 32'(reqReady), 32'd1);
        chk("sp_idle_opValid", 32'(opValid), 32'd0);
        opReady = 1'b0;
        reqValid = 1'b1; reqRa = 2'd1; reqRb = 2'd2; reqRd = 2'd3; reqWb = 1'b1;
        @(negedge clk);
        reqValid = 1'b0; resValid = 1'b1; resData = 8'hEE;
        @(negedge clk);
        resValid = 1'b0;
        chk("sp_opA", 32'(opA), 32'h46);
        chk("sp_readB_bankWR", 32'(bankWR), 32'd0);
        @(negedge clk);
        chk("sp_issue_opValid", 32'(opValid), 32'd1);
        chk("sp_opB", 32'(opB), 32'h77);
        opReady = 1'b1;
        @(negedge clk);
        chk("sp_wait_opValid", 32'(opValid), 32'd0);
        chk("sp_wait_bankWR", 32'(bankWR), 32'd0);
        opReady = 1'b0; resValid = 1'b1; resData = 8'h5A;
        @(negedge clk);
        resValid = 1'b0;
        chk("sp_write_bankWR", 32'(bankWR), 32'd1);
        chk("sp_write_bankRs", 32'(bankRs), 32'd3);
        chk("sp_write_bankData", 32'(bankData), 32'h5A);
        @(negedge clk);
        chk("sp_done", 32'(done), 32'd1);
        chk("sp_opsDone", 32'(opsDone), 32'd6);
        chk("sp_bank_t1", 32'(bank_m[3]), 32'h5A);

        // Reset while in ISSUE aborts the operation.
        opReady = 1'b0; resValid = 1'b0;
        reqValid = 1'b1; reqRa = 2'd0; reqRb = 2'd1; reqRd = 2'd2; reqWb = 1'b1;
        repeat (3) @(negedge clk);
        reqValid = 1'b0;
        chk("ri_pre_opValid", 32'(opValid), 32'd1);
        wr_snap = wr_count;
        done_snap = done_count;
        rst = 1'b1;
        #1;
        chk("ri_opValid", 32'(opValid), 32'd0);
        chk("ri_reqReady", 32'(reqReady), 32'd1);
        chk("ri_opsDone", 32'(opsDone), 32'd0);
        chk("ri_opA", 32'(opA), 32'd0);
        @(negedge clk);
        rst = 1'b0; opReady = 1'b1; resValid = 1'b1; resData = 8'h33;
        repeat (6) @(negedge clk);
        chk("ri_no_write", 32'(wr_count), 32'(wr_snap));
        chk("ri_no_done", 32'(done_count), 32'(done_snap));
        chk("ri_bank_t0", 32'(bank_m[2]), 32'h77);

        // Reset while in WRITE suppresses the write strobe and the done pulse.
        reqValid = 1'b1; reqRa = 2'd0; reqRb = 2'd0; reqRd = 2'd1; reqWb = 1'b1;
        resData = 8'hC3;
        @(negedge clk);
        reqValid = 1'b0;
        repeat (4) @(negedge clk);
        chk("rw_pre_bankWR", 32'(bankWR), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw_bankWR", 32'(bankWR), 32'd0);
        chk("rw_bankData", 32'(bankData), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rw_no_write", 32'(wr_count), 32'(wr_snap));
        chk("rw_no_done", 32'(done_count), 32'(done_snap));
        chk("rw_bank_s1", 32'(bank_m[1]), 32'h46);
        chk("rw_opsDone", 32'(opsDone), 32'd0);

        // Counter wrap over 256 requests without writeback.
        done_snap = done_count;
        for (int i = 0; i < 256; i++) begin
            do_req(2'd1, 2'd1, 2'd0, 1'b0, 8'h00, lat);
            chk("wrap_latency", 32'(lat), 32'd4);
            if (i == 254) begin
                chk("wrap_opsDone_255", 32'(opsDone), 32'd255);
            end
        end
        chk("wrap_opsDone_0", 32'(opsDone), 32'd0);
        @(negedge clk);
        chk("wrap_done_pulses", 32'(done_count - done_snap), 32'd256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reg_port_sequencer.md
# reg_port_sequencer

Initiator-side controller for the processor's single-port register bank (4 × 8-bit registers s0, s1, t0, t1, selected by a 2-bit index, with a write strobe, write data and a combinational read value). It accepts one register-operation request at a time, reads two source registers over the shared port in consecutive cycles, hands the operand pair to the ALU with a valid/ready handshake, waits for the result, and optionally writes it back to a destination register. It sits between instruction decode (upstream) and the register bank and ALU (downstream).

## Interface
- No parameters. Data width is fixed at 8 bits; register index width is fixed at 2 bits.
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- reqValid  in  1  upstream request present
- reqReady  out  1  sequencer can accept a request
- reqRa  in  2  index of source register A
- reqRb  in  2  index of source register B
- reqRd  in  2  index of destination register
- reqWb  in  1  1 = write the result back to reqRd
- bankWR  out  1  register bank write strobe
- bankRs  out  2  register bank index (read or write)
- bankData  out  8  register bank write data
- bankVal  in  8  register bank read value; combinational from bankRs
- opValid  out  1  operands valid toward ALU
- opReady  in  1  ALU accepts operands
- opA  out  8  operand A
- opB  out  8  operand B
- resValid  in  1  ALU result present
- resData  in  8  ALU result
- done  out  1  one-cycle pulse per completed request
- opsDone  out  8  count of completed requests, wraps

## Operation
- States: IDLE, READ_A, READ_B, ISSUE, WAIT_RES, WRITE.
- IDLE: reqReady=1. On reqValid=1, latch reqRa/reqRb/reqRd/reqWb and go to READ_A. Otherwise stay in IDLE.
- READ_A: bankRs=latched Ra, bankWR=0. Capture bankVal into opA. Go to READ_B.
- READ_B: bankRs=latched Rb. Capture bankVal into opB. Go to ISSUE.
- ISSUE: opValid=1. On opReady=1, go to WAIT_RES. opA/opB must stay stable while opValid=1.
- WAIT_RES: on resValid=1, capture resData. If Wb=1, go to WRITE. If Wb=0, go to IDLE and complete.
- WRITE: bankWR=1, bankRs=latched Rd, bankData=captured result, for exactly one cycle. Then go to IDLE and complete.
- Complete: done=1 for the following cycle, and opsDone increments by 1 (mod 256, so 255→0).
- reqReady=0 in every state except IDLE. Upstream holds its request until accepted.
- resValid outside WAIT_RES is ignored. opReady outside ISSUE is ignored.
- When not in WRITE: bankWR=0 and bankData=0. In IDLE, bankRs=0.
- opA/opB hold their last captured values until the next READ_A/READ_B.
- Ra=Rb is legal and yields equal operands. Rd equal to Ra or Rb is legal; the write always occurs after both reads.

## Timing
- Reset (async assert, any state): state=IDLE. reqReady=1. Outputs bankWR, bankRs, bankData, opValid, opA, opB, done and opsDone all =0.
- Reset during WRITE or ISSUE aborts the operation: no write strobe and no done pulse follow.
- Accept at edge E0. READ_A in cycle E0–E1. READ_B in cycle E1–E2. opValid rises after E2.
- Minimum latency with opReady=1 and resValid=1 immediate:
  - Accept edge to done high: 5 cycles when Wb=1, 4 cycles when Wb=0.
- Maximum throughput: one request per 6 cycles (Wb=1) or 5 cycles (Wb=0), because IDLE is re-entered for one cycle between requests.
- ISSUE and WAIT_RES wait indefinitely; there is no timeout.

## Test plan
- Reset check: assert rst mid-ISSUE → next cycle opValid=0, reqReady=1, opsDone=0, no bankWR pulse ever follows.
- Basic writeback: bank s0=0x12, t1=0x34; request Ra=00, Rb=11, Rd=01, Wb=1; ALU returns 0x46 → opA=0x12, opB=0x34, one bankWR pulse with bankRs=01, bankData=0x46, done pulse, opsDone=1.
- No writeback: same request with Wb=0 → bankWR never asserted, done 4 cycles after accept.
- Backpressure: hold opReady=0 for 7 cycles → opValid stays 1, opA/opB stable, reqReady=0; upstream reqValid held is accepted only after done.
- Spurious inputs: pulse resValid during READ_A and opReady during IDLE → ignored; state sequence and result unchanged.
- Counter wrap: run 256 requests with Wb=0 → opsDone returns to 0x00 and 256 done pulses are counted.
